// File: rtl/i2s_tx_sequencer.sv
// i2s_tx_sequencer
// Streams stereo frames from a small host FIFO into the I2S transmitter's
// two-slot sample bank. Each slot is written during the opposite LRCLK half
// so the transmitter never captures a half-updated word. Underflow is
// zero-filled and counted; disabling the block mutes both slots.

module i2s_tx_sequencer #(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          LRCLK,
   input  logic          enable,
   input  logic          host_write,
   input  logic [31:0]   host_left,
   input  logic [31:0]   host_right,
   output logic          host_ready,
   output logic [AW:0]   fifo_level,
   output logic          tx_address,
   output logic          tx_write,
   output logic [31:0]   tx_writedata,
   output logic [15:0]   underflow_count,
   output logic [2:0]    state_out
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_FALL = 3'd1,
      WR_L      = 3'd2,
      WAIT_RISE = 3'd3,
      WR_R      = 3'd4,
      MUTE_L    = 3'd5,
      MUTE_R    = 3'd6
   } state_t;

   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
   localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

   // LRCLK synchronizer and edge detection
   logic [SYNC_STAGES-1:0] syncQ;
   logic                   lrDQ;
   logic                   lrS;
   logic                   lrFall;
   logic                   lrRise;

   // FIFO storage and bookkeeping
   logic [31:0]   memLeft  [DEPTH];
   logic [31:0]   memRight [DEPTH];
   logic [AW-1:0] wrPtrQ, wrPtrD;
   logic [AW-1:0] rdPtrQ, rdPtrD;
   logic [AW:0]   levelQ, levelD;
   logic          fifoEmpty;
   logic          pushEn;
   logic          popReq;
   logic          popEn;

   // Sequencer state and registered transmitter-side outputs
   state_t        stateQ, stateD;
   logic          txWriteQ, txWriteD;
   logic          txAddrQ, txAddrD;
   logic [31:0]   txDataQ, txDataD;
   logic [31:0]   holdQ, holdD;
   logic [15:0]   underflowCountQ, underflowCountD;

   // Bring LRCLK into the CLK domain and keep a one-cycle-delayed copy for edges
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         syncQ <= '0;
         lrDQ  <= 1'b0;
      end else begin
         syncQ <= {syncQ[SYNC_STAGES-2:0], LRCLK};
         lrDQ  <= syncQ[SYNC_STAGES-1];
      end
   end

   assign lrS    = syncQ[SYNC_STAGES-1];
   assign lrFall = ~lrS & lrDQ;
   assign lrRise = lrS & ~lrDQ;

   assign fifoEmpty  = (levelQ == '0);
   assign host_ready = (levelQ != LEVEL_FULL);
   assign pushEn     = host_write & host_ready;
   assign popEn      = popReq & ~fifoEmpty;

   // Frame storage; no reset needed because the level gates every read
   always_ff @(posedge CLK) begin
      if (pushEn) begin
         memLeft[wrPtrQ]  <= host_left;
         memRight[wrPtrQ] <= host_right;
      end
   end

   // Pointer and level update; a simultaneous push and pop leaves the level alone
   always_comb begin
      wrPtrD = wrPtrQ;
      rdPtrD = rdPtrQ;
      levelD = levelQ;
      if (pushEn) begin
         wrPtrD = wrPtrQ + AW'(1);
      end
      if (popEn) begin
         rdPtrD = rdPtrQ + AW'(1);
      end
      case ({pushEn, popEn})
         2'b10:   levelD = levelQ + (AW+1)'(1);
         2'b01:   levelD = levelQ - (AW+1)'(1);
         default: levelD = levelQ;
      endcase
   end

   // FIFO pointer and level registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         levelQ <= '0;
      end else begin
         wrPtrQ <= wrPtrD;
         rdPtrQ <= rdPtrD;
         levelQ <= levelD;
      end
   end

   // Next-state and next-output logic; tx outputs are loaded on entry to a write state
   always_comb begin
      stateD          = stateQ;
      popReq          = 1'b0;
      txWriteD        = 1'b0;
      txAddrD         = txAddrQ;
      txDataD         = txDataQ;
      holdD           = holdQ;
      underflowCountD = underflowCountQ;
      case (stateQ)
         IDLE: begin
            if (enable) begin
               stateD = WAIT_FALL;
            end
         end
         WAIT_FALL: begin
            if (!enable) begin
               stateD   = MUTE_L;
               txWriteD = 1'b1;
               txAddrD  = 1'b0;
               txDataD  = '0;
            end else if (lrFall) begin
               stateD   = WR_L;
               popReq   = 1'b1;
               txWriteD = 1'b1;
               txAddrD  = 1'b0;
               if (!fifoEmpty) begin
                  txDataD = memLeft[rdPtrQ];
                  holdD   = memRight[rdPtrQ];
               end else begin
                  txDataD = '0;
                  holdD   = '0;
                  if (underflowCountQ != COUNT_MAX) begin
                     underflowCountD = underflowCountQ + 16'd1;
                  end
               end
            end
         end
         WR_L: begin
            stateD = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (lrRise) begin
               stateD   = WR_R;
               txWriteD = 1'b1;
               txAddrD  = 1'b1;
               txDataD  = holdQ;
            end
         end
         WR_R: begin
            stateD = WAIT_FALL;
         end
         MUTE_L: begin
            stateD   = MUTE_R;
            txWriteD = 1'b1;
            txAddrD  = 1'b1;
            txDataD  = '0;
         end
         MUTE_R: begin
            stateD = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // Sequencer state, hold register, counter and registered tx outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stateQ          <= IDLE;
         txWriteQ        <= 1'b0;
         txAddrQ         <= 1'b0;
         txDataQ         <= '0;
         holdQ           <= '0;
         underflowCountQ <= '0;
      end else begin
         stateQ          <= stateD;
         txWriteQ        <= txWriteD;
         txAddrQ         <= txAddrD;
         txDataQ         <= txDataD;
         holdQ           <= holdD;
         underflowCountQ <= underflowCountD;
      end
   end

   assign fifo_level      = levelQ;
   assign tx_write        = txWriteQ;
   assign tx_address      = txAddrQ;
   assign tx_writedata    = txDataQ;
   assign underflow_count = underflowCountQ;
   assign state_out       = stateQ;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// tb_i2s_tx_sequencer
// Directed bench for the I2S transmit sequencer: reset, streaming, underflow,
// FIFO full, simultaneous push/pop, disable/mute and counter saturation.

module tb_i2s_tx_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        lrclk;
   logic        enable;
   logic        hostWrite;
   logic [31:0] hostLeft;
   logic [31:0] hostRight;
   logic        hostReady;
   logic [4:0]  fifoLevel;
   logic        txAddress;
   logic        txWrite;
   logic [31:0] txWritedata;
   logic [15:0] underflowCount;
   logic [2:0]  stateOut;

   int checks   = 0;
   int failures = 0;

   i2s_tx_sequencer #(.DEPTH(16), .AW(4), .SYNC_STAGES(2)) dut (
      .CLK             (clk),
      .RESET           (rst),
      .LRCLK           (lrclk),
      .enable          (enable),
      .host_write      (hostWrite),
      .host_left       (hostLeft),
      .host_right      (hostRight),
      .host_ready      (hostReady),
      .fifo_level      (fifoLevel),
      .tx_address      (txAddress),
      .tx_write        (txWrite),
      .tx_writedata    (txWritedata),
      .underflow_count (underflowCount),
      .state_out       (stateOut)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushFrame(input logic [31:0] l, input logic [31:0] r);
      hostLeft  = l;
      hostRight = r;
      hostWrite = 1'b1;
      @(negedge clk);
      hostWrite = 1'b0;
   endtask

   // Bounded wait for the next tx_write pulse, sampled on falling edges
   task automatic waitWrite(output bit got, output int cyc, output logic a, output logic [31:0] d);
      got = 1'b0;
      cyc = 0;
      a   = 1'b0;
      d   = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (txWrite === 1'b1) begin
            got = 1'b1;
            a   = txAddress;
            d   = txWritedata;
            break;
         end
      end
   endtask

   // One full LRCLK period starting in WAIT_FALL with LRCLK high; returns both slot writes
   task automatic runFrame(output bit okL, output logic [31:0] dL, output bit okR, output logic [31:0] dR);
      bit   g;
      int   c;
      logic a;
      lrclk = 1'b0;
      waitWrite(g, c, a, dL);
      okL = g && (a === 1'b0);
      settle(2);
      lrclk = 1'b1;
      waitWrite(g, c, a, dR);
      okR = g && (a === 1'b1);
      settle(2);
   endtask

   task automatic test_reset();
      bit          g;
      int          c;
      logic        a;
      logic [31:0] d;
      int          strobes;
      checks++;
      if (txWrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_write got=%b exp=0", txWrite); end
      checks++;
      if (txAddress !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_address got=%b exp=0", txAddress); end
      checks++;
      if (txWritedata !== 32'h0) begin failures++; $display("[TB] FAIL reset_tx_writedata got=%h exp=0", txWritedata); end
      checks++;
      if (fifoLevel !== 5'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", fifoLevel); end
      checks++;
      if (hostReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_host_ready got=%b exp=1", hostReady); end
      checks++;
      if (underflowCount !== 16'h0) begin failures++; $display("[TB] FAIL reset_underflow got=%h exp=0", underflowCount); end
      checks++;
      if (stateOut !== 3'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", stateOut); end

      // Start a frame, then reset in the right half
      rst = 1'b0;
      settle(3);
      pushFrame(32'hCAFE0001, 32'hCAFE0002);
      enable = 1'b1;
      settle(2);
      lrclk = 1'b0;
      waitWrite(g, c, a, d);
      settle(1);
      rst    = 1'b1;
      enable = 1'b0;
      settle(1);
      checks++;
      if (stateOut !== 3'd0 || fifoLevel !== 5'd0 || txWrite !== 1'b0 || txWritedata !== 32'h0 || hostReady !== 1'b1)
         begin failures++; $display("[TB] FAIL midreset_outputs state=%0d level=%0d wr=%b data=%h ready=%b exp 0/0/0/0/1", stateOut, fifoLevel, txWrite, txWritedata, hostReady); end
      rst   = 1'b0;
      lrclk = 1'b1;
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (txWrite === 1'b1) strobes++;
      end
      checks++;
      if (strobes != 0 || stateOut !== 3'd0) begin failures++; $display("[TB] FAIL midreset_no_mute strobes=%0d state=%0d exp 0/0", strobes, stateOut); end
   endtask

   task automatic test_stream();
      bit          g;
      int          c;
      logic        a;
      logic [31:0] d;
      bit          okL, okR;
      logic [31:0] dL, dR;
      pushFrame(32'h11111111, 32'h22222222);
      pushFrame(32'h33333333, 32'h44444444);
      checks++;
      if (fifoLevel !== 5'd2) begin failures++; $display("[TB] FAIL stream_level_pre got=%0d exp=2", fifoLevel); end
      enable = 1'b1;
      settle(2);
      lrclk = 1'b0;
      waitWrite(g, c, a, d);
      checks++;
      if (!g || a !== 1'b0 || d !== 32'h11111111) begin failures++; $display("[TB] FAIL stream_left1 got=%b addr=%b data=%h exp 1/0/11111111", g, a, d); end
      // LRCLK changes mid-cycle, so two sync flops plus the state register give three edges
      checks++;
      if (c != 3) begin failures++; $display("[TB] FAIL stream_latency got=%0d exp=3", c); end
      checks++;
      if (fifoLevel !== 5'd1) begin failures++; $display("[TB] FAIL stream_level_pop got=%0d exp=1", fifoLevel); end
      settle(2);
      lrclk = 1'b1;
      waitWrite(g, c, a, d);
      checks++;
      if (!g || a !== 1'b1 || d !== 32'h22222222) begin failures++; $display("[TB] FAIL stream_right1 got=%b addr=%b data=%h exp 1/1/22222222", g, a, d); end
      settle(2);
      runFrame(okL, dL, okR, dR);
      checks++;
      if (!okL || !okR || dL !== 32'h33333333 || dR !== 32'h44444444) begin failures++; $display("[TB] FAIL stream_frame2 okL=%b okR=%b L=%h R=%h exp 33333333/44444444", okL, okR, dL, dR); end
      checks++;
      if (fifoLevel !== 5'd0) begin failures++; $display("[TB] FAIL stream_level_end got=%0d exp=0", fifoLevel); end
   endtask

   task automatic test_underflow();
      bit          okL, okR;
      logic [31:0] dL, dR;
      runFrame(okL, dL, okR, dR);
      checks++;
      if (!okL || !okR || dL !== 32'h0 || dR !== 32'h0) begin failures++; $display("[TB] FAIL underflow_zero okL=%b okR=%b L=%h R=%h exp 0/0", okL, okR, dL, dR); end
      checks++;
      if (underflowCount !== 16'd1) begin failures++; $display("[TB] FAIL underflow_count got=%0d exp=1", underflowCount); end
      checks++;
      if (fifoLevel !== 5'd0) begin failures++; $display("[TB] FAIL underflow_level got=%0d exp=0", fifoLevel); end
   endtask

   task automatic test_full();
      bit          okL, okR;
      logic [31:0] dL, dR;
      for (int i = 0; i < 17; i++) begin
         hostLeft  = 32'hA0000000 + i;
         hostRight = 32'hB0000000 + i;
         hostWrite = 1'b1;
         @(negedge clk);
         if (i == 14) begin
            checks++;
            if (hostReady !== 1'b1 || fifoLevel !== 5'd15) begin failures++; $display("[TB] FAIL full_at15 ready=%b level=%0d exp 1/15", hostReady, fifoLevel); end
         end
         if (i == 15) begin
            checks++;
            if (hostReady !== 1'b0 || fifoLevel !== 5'd16) begin failures++; $display("[TB] FAIL full_at16 ready=%b level=%0d exp 0/16", hostReady, fifoLevel); end
         end
      end
      hostWrite = 1'b0;
      checks++;
      if (fifoLevel !== 5'd16) begin failures++; $display("[TB] FAIL full_drop17 level=%0d exp=16", fifoLevel); end
      for (int i = 0; i < 16; i++) begin
         runFrame(okL, dL, okR, dR);
         checks++;
         if (!okL || !okR || dL !== 32'hA0000000 + i || dR !== 32'hB0000000 + i)
            begin failures++; $display("[TB] FAIL full_drain%0d okL=%b okR=%b L=%h R=%h exp %h/%h", i, okL, okR, dL, dR, 32'hA0000000 + i, 32'hB0000000 + i); end
      end
      runFrame(okL, dL, okR, dR);
      checks++;
      if (!okL || !okR || dL !== 32'h0 || dR !== 32'h0 || underflowCount !== 16'd2)
         begin failures++; $display("[TB] FAIL full_zero_fill L=%h R=%h uf=%0d exp 0/0/2", dL, dR, underflowCount); end
   endtask

   task automatic test_push_pop();
      bit          g;
      int          c;
      logic        a;
      logic [31:0] d;
      bit          okL, okR;
      logic [31:0] dL, dR;
      logic [31:0] expL [3];
      logic [31:0] expR [3];
      for (int i = 0; i < 3; i++) pushFrame(32'hC0000000 + i, 32'hD0000000 + i);
      checks++;
      if (fifoLevel !== 5'd3) begin failures++; $display("[TB] FAIL pp_level_pre got=%0d exp=3", fifoLevel); end
      // Push lines up with the pop edge: fall is visible after the second edge
      lrclk = 1'b0;
      settle(2);
      hostLeft  = 32'hE0000001;
      hostRight = 32'hE0000002;
      hostWrite = 1'b1;
      @(negedge clk);
      hostWrite = 1'b0;
      checks++;
      if (txWrite !== 1'b1 || txAddress !== 1'b0 || txWritedata !== 32'hC0000000)
         begin failures++; $display("[TB] FAIL pp_left wr=%b addr=%b data=%h exp 1/0/c0000000", txWrite, txAddress, txWritedata); end
      checks++;
      if (fifoLevel !== 5'd3) begin failures++; $display("[TB] FAIL pp_level_3 got=%0d exp=3", fifoLevel); end
      settle(2);
      lrclk = 1'b1;
      waitWrite(g, c, a, d);
      settle(2);
      expL[0] = 32'hC0000001; expR[0] = 32'hD0000001;
      expL[1] = 32'hC0000002; expR[1] = 32'hD0000002;
      expL[2] = 32'hE0000001; expR[2] = 32'hE0000002;
      for (int i = 0; i < 3; i++) begin
         runFrame(okL, dL, okR, dR);
         checks++;
         if (!okL || !okR || dL !== expL[i] || dR !== expR[i])
            begin failures++; $display("[TB] FAIL pp_order%0d L=%h R=%h exp %h/%h", i, dL, dR, expL[i], expR[i]); end
      end
      // Same alignment with an empty FIFO
      lrclk = 1'b0;
      settle(2);
      hostLeft  = 32'hF0000001;
      hostRight = 32'hF0000002;
      hostWrite = 1'b1;
      @(negedge clk);
      hostWrite = 1'b0;
      checks++;
      if (txWrite !== 1'b1 || txWritedata !== 32'h0 || fifoLevel !== 5'd1 || underflowCount !== 16'd3)
         begin failures++; $display("[TB] FAIL pp_empty wr=%b data=%h level=%0d uf=%0d exp 1/0/1/3", txWrite, txWritedata, fifoLevel, underflowCount); end
      settle(2);
      lrclk = 1'b1;
      waitWrite(g, c, a, d);
      checks++;
      if (!g || a !== 1'b1 || d !== 32'h0) begin failures++; $display("[TB] FAIL pp_empty_right got=%b addr=%b data=%h exp 1/1/0", g, a, d); end
      settle(2);
      runFrame(okL, dL, okR, dR);
      checks++;
      if (!okL || !okR || dL !== 32'hF0000001 || dR !== 32'hF0000002 || underflowCount !== 16'd3)
         begin failures++; $display("[TB] FAIL pp_stored L=%h R=%h uf=%0d exp f0000001/f0000002/3", dL, dR, underflowCount); end
   endtask

   task automatic test_disable();
      bit          g;
      int          c;
      logic        a;
      logic [31:0] d;
      pushFrame(32'h5A5A0001, 32'h5A5A0002);
      lrclk = 1'b0;
      waitWrite(g, c, a, d);
      checks++;
      if (!g || a !== 1'b0 || d !== 32'h5A5A0001) begin failures++; $display("[TB] FAIL dis_left got=%b addr=%b data=%h exp 1/0/5a5a0001", g, a, d); end
      enable = 1'b0;
      settle(1);
      checks++;
      if (stateOut !== 3'd3) begin failures++; $display("[TB] FAIL dis_wait_rise state=%0d exp=3", stateOut); end
      lrclk = 1'b1;
      waitWrite(g, c, a, d);
      checks++;
      if (!g || a !== 1'b1 || d !== 32'h5A5A0002) begin failures++; $display("[TB] FAIL dis_right got=%b addr=%b data=%h exp 1/1/5a5a0002", g, a, d); end
      @(negedge clk);
      checks++;
      if (txWrite !== 1'b0 || stateOut !== 3'd1) begin failures++; $display("[TB] FAIL dis_gap wr=%b state=%0d exp 0/1", txWrite, stateOut); end
      @(negedge clk);
      checks++;
      if (txWrite !== 1'b1 || txAddress !== 1'b0 || txWritedata !== 32'h0 || stateOut !== 3'd5)
         begin failures++; $display("[TB] FAIL dis_mute_l wr=%b addr=%b data=%h state=%0d exp 1/0/0/5", txWrite, txAddress, txWritedata, stateOut); end
      @(negedge clk);
      checks++;
      if (txWrite !== 1'b1 || txAddress !== 1'b1 || txWritedata !== 32'h0 || stateOut !== 3'd6)
         begin failures++; $display("[TB] FAIL dis_mute_r wr=%b addr=%b data=%h state=%0d exp 1/1/0/6", txWrite, txAddress, txWritedata, stateOut); end
      @(negedge clk);
      checks++;
      if (txWrite !== 1'b0 || stateOut !== 3'd0) begin failures++; $display("[TB] FAIL dis_idle wr=%b state=%0d exp 0/0", txWrite, stateOut); end
   endtask

   task automatic test_saturate();
      bit          okL, okR;
      logic [31:0] dL, dR;
      // Jump the counter close to its ceiling instead of running 65k frames
      force dut.underflowCountQ = 16'hFFFE;
      settle(2);
      release dut.underflowCountQ;
      enable = 1'b1;
      settle(2);
      runFrame(okL, dL, okR, dR);
      checks++;
      if (underflowCount !== 16'hFFFF || dL !== 32'h0 || dR !== 32'h0)
         begin failures++; $display("[TB] FAIL sat_reach uf=%h L=%h R=%h exp ffff/0/0", underflowCount, dL, dR); end
      runFrame(okL, dL, okR, dR);
      checks++;
      if (underflowCount !== 16'hFFFF || !okL || !okR) begin failures++; $display("[TB] FAIL sat_hold uf=%h okL=%b okR=%b exp ffff/1/1", underflowCount, okL, okR); end
      checks++;
      if (fifoLevel !== 5'd0) begin failures++; $display("[TB] FAIL sat_level got=%0d exp=0", fifoLevel); end
   endtask

   initial begin
      rst       = 1'b1;
      lrclk     = 1'b1;
      enable    = 1'b0;
      hostWrite = 1'b0;
      hostLeft  = '0;
      hostRight = '0;
      settle(3);
      $display("[TB] reset");
      test_reset();
      $display("[TB] stream");
      test_stream();
      $display("[TB] underflow");
      test_underflow();
      $display("[TB] full");
      test_full();
      $display("[TB] push/pop");
      test_push_pop();
      $display("[TB] disable");
      test_disable();
      $display("[TB] saturate");
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
